// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bundle between the PC sequencer and its driver: redirect/stall/halt
// controls toward the sequencer, PC and fetch status back out.
interface pc_fetch_if #(
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned IMM_W  = 16;
   localparam int unsigned JIDX_W = 26;

   logic              stall;
   logic              branch_taken;
   logic [IMM_W-1:0]  branch_imm;
   logic              jump;
   logic [JIDX_W-1:0] jump_index;
   logic              halt_req;

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus4;
   logic              fetch_valid;
   logic              halted;
   logic [CNT_W-1:0]  retired_cnt;

   modport master (
      output stall, branch_taken, branch_imm, jump, jump_index, halt_req,
      input  pc, pc_plus4, fetch_valid, halted, retired_cnt
   );

   modport slave (
      input  stall, branch_taken, branch_imm, jump, jump_index, halt_req,
      output pc, pc_plus4, fetch_valid, halted, retired_cnt
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: boot hold, sequential step, beq/j redirect,
// stall, halt on end of address space or self-loop, saturating retired-fetch count.
module pc_fetch_unit #(
   parameter int unsigned ADDR_W      = 7,
   parameter int unsigned BOOT_CYCLES = 2,
   parameter int unsigned CNT_W       = 16
) (
   input  logic       clk,
   input  logic       reset,
   pc_fetch_if.slave  fb
);
   localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [ADDR_W-1:0] PC_LAST   = ~ADDR_W'(3);
   localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t            state;
   logic [BOOT_W-1:0] boot_cnt;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_plus4_q;
   logic              fetch_valid_q;
   logic              halted_q;
   logic [CNT_W-1:0]  retired_q;

   logic [ADDR_W-1:0] seq_pc_c;
   logic [ADDR_W-1:0] tgt_j_c;
   logic [ADDR_W-1:0] tgt_b_c;
   logic [ADDR_W-1:0] next_pc_c;
   logic              redirect_c;
   logic              stop_c;

   // Only the low word-index bits of the jump field reach a 2^ADDR_W byte space.
   logic unused_jidx;
   assign unused_jidx = ^fb.jump_index[25:ADDR_W-2];

   // Next-PC selection; stall and halt_req are resolved in the sequential block.
   always_comb begin
      seq_pc_c   = pc_q + PC_STEP;
      tgt_j_c    = {fb.jump_index[ADDR_W-3:0], 2'b00};
      tgt_b_c    = seq_pc_c + ADDR_W'({{14{fb.branch_imm[15]}}, fb.branch_imm, 2'b00});
      redirect_c = fb.jump | fb.branch_taken;
      next_pc_c  = fb.jump ? tgt_j_c : (fb.branch_taken ? tgt_b_c : seq_pc_c);
      stop_c     = redirect_c ? (next_pc_c == pc_q) : (pc_q == PC_LAST);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_BOOT;
         boot_cnt      <= '0;
         pc_q          <= '0;
         pc_plus4_q    <= PC_STEP;
         fetch_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         retired_q     <= '0;
      end else begin
         case (state)
            S_BOOT: begin
               if (boot_cnt == BOOT_LAST) begin
                  state         <= S_RUN;
                  boot_cnt      <= '0;
                  fetch_valid_q <= 1'b1;
               end else begin
                  boot_cnt <= boot_cnt + BOOT_W'(1);
               end
            end
            S_RUN: begin
               if (fb.halt_req) begin
                  state         <= S_HALT;
                  fetch_valid_q <= 1'b0;
                  halted_q      <= 1'b1;
               end else if (!fb.stall) begin
                  if (retired_q != CNT_MAX) retired_q <= retired_q + CNT_W'(1);
                  // End-of-space and self-loop both retire the fetch, then freeze.
                  if (stop_c) begin
                     state         <= S_HALT;
                     fetch_valid_q <= 1'b0;
                     halted_q      <= 1'b1;
                  end else begin
                     pc_q       <= next_pc_c;
                     pc_plus4_q <= next_pc_c + PC_STEP;
                  end
               end
            end
            S_HALT: begin
               fetch_valid_q <= 1'b0;
               halted_q      <= 1'b1;
            end
            default: begin
               state         <= S_BOOT;
               boot_cnt      <= '0;
               pc_q          <= '0;
               pc_plus4_q    <= PC_STEP;
               fetch_valid_q <= 1'b0;
               halted_q      <= 1'b0;
            end
         endcase
      end
   end

   assign fb.pc          = pc_q;
   assign fb.pc_plus4    = pc_plus4_q;
   assign fb.fetch_valid = fetch_valid_q;
   assign fb.halted      = halted_q;
   assign fb.retired_cnt = retired_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized runs against a
// cycle-level reference model built from the fetch rules.
module tb_pc_fetch_unit;
   localparam int unsigned ADDR_W = 7;
   localparam int unsigned CNT_W  = 16;
   localparam int          SPACE  = 128;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pc_fetch_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   pc_fetch_unit #(.ADDR_W(ADDR_W), .BOOT_CYCLES(2), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .fb    (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: phase 0 = booting, 1 = running, 2 = halted
   int m_phase;
   int m_boot_left;
   int m_pc;
   int m_cnt;

   task automatic model_reset();
      m_phase = 0; m_boot_left = 2; m_pc = 0; m_cnt = 0;
   endtask

   task automatic model_edge(input logic st, input logic bt, input logic [15:0] imm,
                             input logic j, input logic [25:0] ji, input logic hr);
      int tgt;
      int simm;
      bit redirect;
      if (m_phase == 0) begin
         m_boot_left--;
         if (m_boot_left == 0) m_phase = 1;
      end else if (m_phase == 1) begin
         if (hr) begin
            m_phase = 2;
         end else if (!st) begin
            simm     = $signed(imm);
            redirect = j || bt;
            if (j)       tgt = (int'(ji) % 32) * 4;
            else if (bt) tgt = (((m_pc + 4 + simm * 4) % SPACE) + SPACE) % SPACE;
            else         tgt = m_pc + 4;
            if (m_cnt < 65535) m_cnt++;
            if (!redirect && m_pc == SPACE - 4) m_phase = 2;
            else if (redirect && tgt == m_pc)   m_phase = 2;
            else                                m_pc = tgt;
         end
      end
   endtask

   task automatic check_all(input string tag);
      checks += 5;
      assert (bus.pc === ADDR_W'(m_pc)) else begin
         errors++; $error("FAIL %s pc: observed %0h expected %0h", tag, bus.pc, m_pc);
      end
      assert (bus.pc_plus4 === ADDR_W'((m_pc + 4) % SPACE)) else begin
         errors++; $error("FAIL %s pc_plus4: observed %0h expected %0h", tag, bus.pc_plus4, (m_pc + 4) % SPACE);
      end
      assert (bus.fetch_valid === (m_phase == 1)) else begin
         errors++; $error("FAIL %s fetch_valid: observed %b expected %b", tag, bus.fetch_valid, m_phase == 1);
      end
      assert (bus.halted === (m_phase == 2)) else begin
         errors++; $error("FAIL %s halted: observed %b expected %b", tag, bus.halted, m_phase == 2);
      end
      assert (bus.retired_cnt === CNT_W'(m_cnt)) else begin
         errors++; $error("FAIL %s retired_cnt: observed %0d expected %0d", tag, bus.retired_cnt, m_cnt);
      end
   endtask

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++; $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic st, input logic bt, input logic [15:0] imm,
                       input logic j, input logic [25:0] ji, input logic hr);
      bus.stall = st; bus.branch_taken = bt; bus.branch_imm = imm;
      bus.jump = j; bus.jump_index = ji; bus.halt_req = hr;
      @(posedge clk);
      model_edge(st, bt, imm, j, ji, hr);
      #1;
      check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 1'b0, 16'h0, 1'b0, 26'h0, 1'b0);
   endtask

   task automatic do_reset();
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_imm = '0;
      bus.jump = 1'b0; bus.jump_index = '0; bus.halt_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b1;
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_imm = '0;
      bus.jump = 1'b0; bus.jump_index = '0; bus.halt_req = 1'b0;
      #2;

      // Boot window then sequential fetch
      do_reset();
      check_val("reset_pc", 32'(bus.pc), 32'h0);
      idle("boot1");
      check_val("boot1_fv", 32'(bus.fetch_valid), 32'h0);
      idle("boot2");
      check_val("run_fv", 32'(bus.fetch_valid), 32'h1);
      idle("seq"); check_val("seq_04", 32'(bus.pc), 32'h04);
      idle("seq"); check_val("seq_08", 32'(bus.pc), 32'h08);
      idle("seq"); check_val("seq_0c", 32'(bus.pc), 32'h0C);
      idle("seq"); check_val("seq_10", 32'(bus.pc), 32'h10);

      // Stall beats a pending jump; redirect taken once released
      for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 16'h0, 1'b1, 26'h08, 1'b0);
      check_val("stall_pc", 32'(bus.pc), 32'h10);
      check_val("stall_cnt", 32'(bus.retired_cnt), 32'd4);
      step("unstall_jump", 1'b0, 1'b0, 16'h0, 1'b1, 26'h08, 1'b0);
      check_val("unstall_pc", 32'(bus.pc), 32'h20);

      step("beq", 1'b0, 1'b1, 16'd9, 1'b0, 26'h0, 1'b0);
      check_val("beq_pc", 32'(bus.pc), 32'h48);
      step("jump", 1'b0, 1'b0, 16'h0, 1'b1, 26'h11, 1'b0);
      check_val("jump_44", 32'(bus.pc), 32'h44);
      step("jump", 1'b0, 1'b0, 16'h0, 1'b1, 26'h0E, 1'b0);
      check_val("jump_38", 32'(bus.pc), 32'h38);
      step("jump_beq", 1'b0, 1'b1, 16'd5, 1'b1, 26'h08, 1'b0);
      check_val("jump_wins", 32'(bus.pc), 32'h20);
      step("self_loop", 1'b0, 1'b1, 16'hFFFF, 1'b0, 26'h0, 1'b0);
      check_val("self_loop_halt", 32'(bus.halted), 32'h1);
      check_val("self_loop_pc", 32'(bus.pc), 32'h20);
      check_val("self_loop_cnt", 32'(bus.retired_cnt), 32'd10);
      for (int i = 0; i < 3; i++) step("halt_hold", 1'b0, 1'b1, 16'd3, 1'b1, 26'h05, 1'b0);

      // End of address space
      do_reset();
      idle("boot"); idle("boot");
      for (int i = 0; i < 31; i++) idle("walk");
      check_val("walk_7c", 32'(bus.pc), 32'h7C);
      idle("end_space");
      check_val("end_halt", 32'(bus.halted), 32'h1);
      check_val("end_pc", 32'(bus.pc), 32'h7C);
      check_val("end_fv", 32'(bus.fetch_valid), 32'h0);
      check_val("end_cnt", 32'(bus.retired_cnt), 32'd32);

      // Async reset between edges, boot again, then halt_req
      do_reset();
      idle("boot"); idle("boot");
      for (int i = 0; i < 3; i++) idle("pre_reset");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check_all("mid_reset");
      check_val("mid_reset_pc", 32'(bus.pc), 32'h0);
      check_val("mid_reset_fv", 32'(bus.fetch_valid), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      idle("reboot1");
      check_val("reboot1_fv", 32'(bus.fetch_valid), 32'h0);
      idle("reboot2");
      check_val("reboot2_fv", 32'(bus.fetch_valid), 32'h1);
      idle("seq"); idle("seq");
      step("halt_req", 1'b0, 1'b1, 16'd2, 1'b0, 26'h0, 1'b1);
      check_val("halt_req_halted", 32'(bus.halted), 32'h1);
      check_val("halt_req_pc", 32'(bus.pc), 32'h08);
      check_val("halt_req_cnt", 32'(bus.retired_cnt), 32'd2);

      // Randomized runs
      for (int r = 0; r < 6; r++) begin
         do_reset();
         for (int i = 0; i < 250; i++) begin
            logic st, bt, j, hr;
            logic [15:0] imm;
            logic [25:0] ji;
            st  = ($urandom_range(0, 4) == 0);
            bt  = ($urandom_range(0, 4) == 0);
            j   = ($urandom_range(0, 9) == 0);
            hr  = ($urandom_range(0, 199) == 0);
            imm = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            ji  = 26'($urandom);
            step("rand", st, bt, imm, j, ji, hr);
            if (m_phase == 2 && $urandom_range(0, 3) == 0) break;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
